// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid, stall, flush and tNew countdown.
// Define PIPE_STAGE_PERF_CNT_EN to build the saturating stall/bubble performance counters.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 64,
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned T_W      = 5,
    parameter int unsigned TNEW_DEC = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_we,
    input  logic [4:0]        in_wa,
    input  logic [31:0]       in_wd,
    input  logic [T_W-1:0]    in_tnew,
    input  logic [T_W-1:0]    in_tuse_rs,
    input  logic [T_W-1:0]    in_tuse_rt,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_we,
    output logic [4:0]        out_wa,
    output logic [31:0]       out_wd,
    output logic [T_W-1:0]    out_tnew,
    output logic [T_W-1:0]    out_tuse_rs,
    output logic [T_W-1:0]    out_tuse_rt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int unsigned PC_W = 32;
    localparam int unsigned RA_W = 5;

    logic              valid_q,  valid_d;
    logic [PC_W-1:0]   pc_q,     pc_d;
    logic [PC_W-1:0]   instr_q,  instr_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic              we_q,     we_d;
    logic [RA_W-1:0]   wa_q,     wa_d;
    logic [PC_W-1:0]   wd_q,     wd_d;
    logic [T_W-1:0]    tnew_q,   tnew_d;
    logic [T_W-1:0]    rs_q,     rs_d;
    logic [T_W-1:0]    rt_q,     rt_d;

    logic [T_W-1:0]    tnew_next_c;
    logic              we_gated_c;
    logic              load_c;

    // tNew counts down by one per stage, saturating at zero.
    always_comb begin
        tnew_next_c = in_tnew;
        if ((TNEW_DEC != 0) && (in_tnew != '0)) begin
            tnew_next_c = in_tnew - T_W'(1);
        end
    end

    // A bubble or a $zero target never writes the register file.
    assign we_gated_c = in_we && in_valid && (in_wa != '0);
    assign load_c     = !flush && !stall;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        data_d  = data_q;
        we_d    = we_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        tnew_d  = tnew_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = PC_RESET;
            instr_d = '0;
            data_d  = '0;
            we_d    = 1'b0;
            wa_d    = '0;
            wd_d    = '0;
            tnew_d  = '0;
            rs_d    = '0;
            rt_d    = '0;
        end else if (load_c) begin
            valid_d = in_valid;
            pc_d    = in_pc;
            instr_d = in_instr;
            data_d  = in_data;
            we_d    = we_gated_c;
            wa_d    = in_wa;
            wd_d    = in_wd;
            tnew_d  = tnew_next_c;
            rs_d    = in_tuse_rs;
            rt_d    = in_tuse_rt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= PC_RESET;
            instr_q <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            tnew_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            tnew_q  <= tnew_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_instr   = instr_q;
    assign out_data    = data_q;
    assign out_we      = we_q;
    assign out_wa      = wa_q;
    assign out_wd      = wd_q;
    assign out_tnew    = tnew_q;
    assign out_tuse_rs = rs_q;
    assign out_tuse_rt = rt_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             stall_ev_c;
    logic             bubble_ev_c;

    // A load of an invalid slot counts as a bubble just like a flush.
    assign stall_ev_c  = stall && !flush;
    assign bubble_ev_c = flush || (load_c && !in_valid);

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_ev_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (bubble_ev_c && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed plus randomized bench for pipe_stage_reg against a behavioural slot model.
// Counter expectations follow PIPE_STAGE_PERF_CNT_EN; counters are 4 bits wide here.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned T_W    = 5;
    localparam int unsigned CNT_W  = 4;
    localparam int          CNT_MAX = 15;
`ifdef PIPE_STAGE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk, reset, stall, flush;
    logic              in_valid, in_we;
    logic [31:0]       in_pc, in_instr, in_wd;
    logic [DATA_W-1:0] in_data;
    logic [4:0]        in_wa;
    logic [T_W-1:0]    in_tnew, in_tuse_rs, in_tuse_rt;
    logic              out_valid, out_we;
    logic [31:0]       out_pc, out_instr, out_wd;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        out_wa;
    logic [T_W-1:0]    out_tnew, out_tuse_rs, out_tuse_rt;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    pipe_stage_reg #(.DATA_W(DATA_W), .PC_RESET(32'h0000_3000), .T_W(T_W),
                     .TNEW_DEC(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data),
        .in_we(in_we), .in_wa(in_wa), .in_wd(in_wd), .in_tnew(in_tnew),
        .in_tuse_rs(in_tuse_rs), .in_tuse_rt(in_tuse_rt),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_data(out_data),
        .out_we(out_we), .out_wa(out_wa), .out_wd(out_wd), .out_tnew(out_tnew),
        .out_tuse_rs(out_tuse_rs), .out_tuse_rt(out_tuse_rt),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference slot contents.
    logic        m_valid, m_we;
    logic [31:0] m_pc, m_instr, m_wd;
    logic [63:0] m_data;
    logic [4:0]  m_wa;
    int          m_tnew, m_rs, m_rt, m_scnt, m_bcnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_bubble();
        m_valid = 1'b0; m_pc = 32'h0000_3000; m_instr = '0; m_data = '0;
        m_we = 1'b0; m_wa = '0; m_wd = '0; m_tnew = 0; m_rs = 0; m_rt = 0;
    endtask

    task automatic model_reset();
        model_bubble();
        m_scnt = 0;
        m_bcnt = 0;
    endtask

    // Slot behaviour at a rising edge: flush beats stall beats load.
    task automatic model_edge();
        if (flush) begin
            model_bubble();
            if (m_bcnt < CNT_MAX) m_bcnt++;
        end else if (stall) begin
            if (m_scnt < CNT_MAX) m_scnt++;
        end else begin
            m_valid = in_valid;
            m_pc    = in_pc;
            m_instr = in_instr;
            m_data  = in_data;
            m_wa    = in_wa;
            m_wd    = in_wd;
            m_we    = in_valid && in_we && (int'(in_wa) != 0);
            m_tnew  = (int'(in_tnew) > 0) ? int'(in_tnew) - 1 : 0;
            m_rs    = int'(in_tuse_rs);
            m_rt    = int'(in_tuse_rt);
            if (!in_valid && m_bcnt < CNT_MAX) m_bcnt++;
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".valid"}, 64'(out_valid), 64'(m_valid));
        check({ctx, ".pc"},    64'(out_pc),    64'(m_pc));
        check({ctx, ".instr"}, 64'(out_instr), 64'(m_instr));
        check({ctx, ".data"},  out_data,       m_data);
        check({ctx, ".we"},    64'(out_we),    64'(m_we));
        check({ctx, ".wa"},    64'(out_wa),    64'(m_wa));
        check({ctx, ".wd"},    64'(out_wd),    64'(m_wd));
        check({ctx, ".tnew"},  64'(out_tnew),  64'(m_tnew));
        check({ctx, ".rs"},    64'(out_tuse_rs), 64'(m_rs));
        check({ctx, ".rt"},    64'(out_tuse_rt), 64'(m_rt));
        check({ctx, ".scnt"},  64'(stall_cnt),  PERF ? 64'(m_scnt) : 64'd0);
        check({ctx, ".bcnt"},  64'(bubble_cnt), PERF ? 64'(m_bcnt) : 64'd0);
    endtask

    task automatic tick(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        check_all(ctx);
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic we,
                          input logic [4:0] wa, input logic [T_W-1:0] tn);
        in_valid = v; in_pc = pc; in_we = we; in_wa = wa; in_tnew = tn;
        in_instr = 32'h8C88_0004; in_data = {pc, ~pc}; in_wd = pc ^ 32'h5A5A_0000;
        in_tuse_rs = T_W'(1); in_tuse_rt = T_W'(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 5'd0, '0);
        model_reset();
        #3;
        check_all("reset");

        // First edge after release carries a stall: reset values are held.
        @(negedge clk);
        reset = 1'b0; stall = 1'b1;
        set_in(1'b1, 32'h0000_3100, 1'b1, 5'd3, T_W'(4));
        tick("rel_stall");
        stall = 1'b0;

        set_in(1'b1, 32'h0000_3004, 1'b1, 5'd8, T_W'(2));
        tick("load");
        check("load.pc_lit", 64'(out_pc), 64'h3004);
        check("load.tnew_lit", 64'(out_tnew), 64'd1);
        set_in(1'b1, 32'h0000_3008, 1'b1, 5'd8, T_W'(0));
        tick("tnew0");
        check("tnew0.lit", 64'(out_tnew), 64'd0);

        set_in(1'b1, 32'h0000_3008, 1'b1, 5'd9, T_W'(3));
        tick("load3008");
        stall = 1'b1;
        set_in(1'b1, 32'h0000_300C, 1'b1, 5'd10, T_W'(7));
        for (int i = 0; i < 3; i++) tick("stall");
        check("stall.pc_lit", 64'(out_pc), 64'h3008);
        check("stall.tnew_lit", 64'(out_tnew), 64'd2);

        flush = 1'b1;
        tick("flush_stall");
        check("flush.pc_lit", 64'(out_pc), 64'h3000);
        flush = 1'b0; stall = 1'b0;

        set_in(1'b1, 32'h0000_3010, 1'b1, 5'd0, T_W'(1));
        tick("wa0");
        check("wa0.we_lit", 64'(out_we), 64'd0);
        set_in(1'b0, 32'h0000_3010, 1'b1, 5'd5, T_W'(1));
        tick("invalid_we");
        check("invalid.wa_lit", 64'(out_wa), 64'd5);

        // Asynchronous reset mid-cycle takes effect before the next edge.
        set_in(1'b1, 32'h0000_3010, 1'b1, 5'd6, T_W'(2));
        tick("pre_reset");
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b1, 32'h0000_3014, 1'b1, 5'd7, T_W'(3));
        tick("rel_load");

        stall = 1'b1;
        for (int i = 0; i < 20; i++) tick("sat");
        check("sat.scnt_lit", 64'(stall_cnt), PERF ? 64'd15 : 64'd0);
        stall = 1'b0;

        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            in_valid   = ($urandom_range(0, 4) != 0);
            in_pc      = $urandom;
            in_instr   = $urandom;
            in_data    = {$urandom, $urandom};
            in_we      = $urandom_range(0, 1) == 1;
            in_wa      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            in_wd      = $urandom;
            in_tnew    = ($urandom_range(0, 1) == 0) ? T_W'($urandom_range(0, 3)) : T_W'($urandom);
            in_tuse_rs = T_W'($urandom);
            in_tuse_rt = T_W'($urandom);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
